stream_packer: RTL and testbench

Width-upsizing stage placed directly downstream of the skid buffer on the valid/ready stream. It accepts narrow `DWIDTH` beats and packs `RATIO` consecutive beats into one `DWIDTH*RATIO` output word. An optional `i_data_last` flushes a partial word early, and per-lane keep bits mark which lanes are valid. Full input throughput is one beat per cycle; full output throughput is one word per `RATIO` cycles.

---
 rtl/stream_pkg.sv | 33 +++
 rtl/stream_out_reg.sv | 45 ++++
 rtl/stream_packer.sv | 94 +++++++++
 tb/tb_stream_packer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared definitions for the stream width-conversion blocks.
// Provides lane_mask() for keep generation and STREAM_RATIO_CHECK for
// elaboration-time rejection of a lane ratio below 2.
`ifndef STREAM_PKG_SV
`define STREAM_PKG_SV

// Stops elaboration when a packer is built with fewer than two lanes,
// where there would be nothing to pack.
`define STREAM_RATIO_CHECK(r) \
    if ((r) < 2) begin : g_ratio_check \
        $error("stream: RATIO must be >= 2"); \
    end

package stream_pkg;

    localparam int unsigned MAX_LANES = 32;

    // Keep vector with lanes 0..cnt set, limited to 'ratio' lanes.
    function automatic logic [MAX_LANES-1:0] lane_mask(input int unsigned cnt,
                                                       input int unsigned ratio);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int unsigned k = 0; k < MAX_LANES; k++) begin
            if ((k <= cnt) && (k < ratio)) begin
                m[k] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

`endif

// File: rtl/stream_out_reg.sv
// Output holding register for a packed word: data/keep/last/valid.
// Latency: a load is visible the cycle after the loading edge.
// Backpressure: word held stable while valid & !take; load overrides a same-edge pop.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   load, load_data,  capture a new word (wins over pop on the same edge)
//   load_keep, load_last
//   take              downstream accepts the word when valid
//   data, keep, last, valid   registered word presented downstream
module stream_out_reg #(
    parameter int DW = 32,
    parameter int KW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic [KW-1:0] load_keep,
    input  logic          load_last,
    input  logic          take,
    output logic [DW-1:0] data,
    output logic [KW-1:0] keep,
    output logic          last,
    output logic          valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            keep  <= '0;
            last  <= 1'b0;
            valid <= 1'b0;
        end else if (load) begin
            // Also covers load-while-popping: new word replaces the old, no bubble.
            data  <= load_data;
            keep  <= load_keep;
            last  <= load_last;
            valid <= 1'b1;
        end else if (valid && take) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_packer.sv
// Packs RATIO consecutive DWIDTH beats into one word, little-endian lane fill.
// Latency: word valid the cycle after its completing beat is accepted.
// Backpressure: only the completing beat stalls, while a word is pending and i_data_ready is low.
//
// Ports:
//   i_clock, i_reset_n                       clock, async active-low reset
//   i_data, i_data_valid, i_data_last        narrow input beat (last flushes early)
//   o_data_ready                             input beat accepted this cycle
//   o_data, o_data_keep, o_data_last         packed word, per-lane keep, early-close flag
//   o_data_valid, i_data_ready               output handshake
module stream_packer
    import stream_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int RATIO  = 4
) (
    input  logic                    i_clock,
    input  logic                    i_reset_n,
    input  logic [DWIDTH-1:0]       i_data,
    input  logic                    i_data_valid,
    input  logic                    i_data_last,
    output logic                    o_data_ready,
    output logic [DWIDTH*RATIO-1:0] o_data,
    output logic [RATIO-1:0]        o_data_keep,
    output logic                    o_data_last,
    output logic                    o_data_valid,
    input  logic                    i_data_ready
);

    `STREAM_RATIO_CHECK(RATIO)

    localparam int            CW        = $clog2(RATIO);
    localparam int            WW        = DWIDTH * RATIO;
    localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

    logic [CW-1:0]              cnt;
    // Only lanes 0..RATIO-2 are stored; the top lane always comes straight from i_data.
    logic [DWIDTH*(RATIO-1)-1:0] acc;

    logic          would_complete;
    logic          accept;
    logic          load;
    logic [WW-1:0] word;
    logic [RATIO-1:0] keep_next;

    assign would_complete = (cnt == LAST_LANE) || i_data_last;

    // i_data_ready only matters when this beat would have to land in the output register.
    assign o_data_ready = !would_complete || !o_data_valid || i_data_ready;
    assign accept       = i_data_valid && o_data_ready;
    assign load         = accept && would_complete;

    // acc lanes at and above cnt are always zero (cleared on every completion and
    // on reset), so overlaying the new beat at lane cnt gives zeroed upper lanes.
    always_comb begin
        word = {{DWIDTH{1'b0}}, acc};
        word[cnt*DWIDTH +: DWIDTH] = i_data;
    end

    assign keep_next = RATIO'(lane_mask(32'(cnt), RATIO));

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt <= '0;
            acc <= '0;
        end else if (accept) begin
            if (would_complete) begin
                cnt <= '0;
                acc <= '0;
            end else begin
                acc[cnt*DWIDTH +: DWIDTH] <= i_data;
                cnt                       <= cnt + CW'(1);
            end
        end
    end

    stream_out_reg #(
        .DW (WW),
        .KW (RATIO)
    ) u_out_reg (
        .clk       (i_clock),
        .rst_n     (i_reset_n),
        .load      (load),
        .load_data (word),
        .load_keep (keep_next),
        .load_last (i_data_last),
        .take      (i_data_ready),
        .data      (o_data),
        .keep      (o_data_keep),
        .last      (o_data_last),
        .valid     (o_data_valid)
    );

endmodule

// File: tb/tb_stream_packer.sv
// Self-checking bench for stream_packer (DWIDTH=8, RATIO=4): directed steps plus
// a reference model that pushes expected words into a queue as beats are accepted
// and pops them as words leave the DUT.
module tb_stream_packer;

    localparam int DW = 8;
    localparam int R  = 4;
    localparam int WW = DW * R;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] i_data;
    logic          i_data_valid;
    logic          i_data_last;
    logic          o_data_ready;
    logic [WW-1:0] o_data;
    logic [R-1:0]  o_data_keep;
    logic          o_data_last;
    logic          o_data_valid;
    logic          i_data_ready;

    int checks = 0;
    int errors = 0;

    // Expected word entries: {data, keep, last}
    logic [WW+R:0] sbq[$];
    logic [DW-1:0] mlanes[R];
    int            mcnt;
    logic [WW-1:0] mw;
    logic [R-1:0]  mk;
    logic [WW+R:0] exp_word;
    logic          held_vld;
    logic [WW+R:0] held_word;
    logic          rand_en = 1'b0;
    int            w;

    always #5 clk = ~clk;

    stream_packer #(
        .DWIDTH (DW),
        .RATIO  (R)
    ) dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .i_data_last  (i_data_last),
        .o_data_ready (o_data_ready),
        .o_data       (o_data),
        .o_data_keep  (o_data_keep),
        .o_data_last  (o_data_last),
        .o_data_valid (o_data_valid),
        .i_data_ready (i_data_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one beat until accepted (bounded); waits = stalled cycles.
    task automatic beat(input logic [DW-1:0] d, input logic last, output int waits);
        bit done;
        done  = 1'b0;
        waits = 0;
        i_data       = d;
        i_data_last  = last;
        i_data_valid = 1'b1;
        while (!done && waits < 200) begin
            @(negedge clk);
            done = o_data_ready;
            @(posedge clk);
            #1;
            if (!done) waits++;
        end
        chk("beat_accepted", 64'(done), 64'd1);
        i_data_valid = 1'b0;
        i_data_last  = 1'b0;
    endtask

    task automatic chk_word(input string tag, input logic [WW-1:0] d, input logic [R-1:0] k,
                            input logic l);
        chk({tag, "_valid"}, 64'(o_data_valid), 64'd1);
        chk({tag, "_data"},  64'(o_data),       64'(d));
        chk({tag, "_keep"},  64'(o_data_keep),  64'(k));
        chk({tag, "_last"},  64'(o_data_last),  64'(l));
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_valid"}, 64'(o_data_valid), 64'd0);
        chk({tag, "_data"},  64'(o_data),       64'd0);
        chk({tag, "_keep"},  64'(o_data_keep),  64'd0);
        chk({tag, "_last"},  64'(o_data_last),  64'd0);
        chk({tag, "_ready"}, 64'(o_data_ready), 64'd1);
    endtask

    // Monitor + reference model, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
            mcnt = 0;
            foreach (mlanes[k]) mlanes[k] = '0;
            held_vld = 1'b0;
        end else begin
            if (held_vld && o_data_valid)
                chk("hold_stable", 64'({o_data, o_data_keep, o_data_last}), 64'(held_word));
            held_vld  = o_data_valid && !i_data_ready;
            held_word = {o_data, o_data_keep, o_data_last};

            if (o_data_valid && i_data_ready) begin
                chk("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
                if (sbq.size() != 0) begin
                    exp_word = sbq.pop_front();
                    chk("sb_word", 64'({o_data, o_data_keep, o_data_last}), 64'(exp_word));
                end
            end

            if (i_data_valid && o_data_ready) begin
                mlanes[mcnt] = i_data;
                if (mcnt == R - 1 || i_data_last) begin
                    mw = '0;
                    for (int k = 0; k <= mcnt; k++) mw[k*DW +: DW] = mlanes[k];
                    mk = R'((1 << (mcnt + 1)) - 1);
                    sbq.push_back({mw, mk, i_data_last});
                    foreach (mlanes[k]) mlanes[k] = '0;
                    mcnt = 0;
                end else begin
                    mcnt++;
                end
            end
        end
    end

    // Random downstream readiness during the soak phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_en) i_data_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        i_data       = '0;
        i_data_valid = 1'b0;
        i_data_last  = 1'b0;
        i_data_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_cleared("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Streaming, back-to-back, downstream always ready
        for (int i = 1; i <= 8; i++) begin
            beat(DW'(i), 1'b0, w);
            chk("stream_ready", 64'(w), 64'd0);
            if (i == 4) chk_word("stream_w0", 32'h04030201, 4'b1111, 1'b0);
            if (i == 8) chk_word("stream_w1", 32'h08070605, 4'b1111, 1'b0);
        end
        @(posedge clk);
        #1;
        chk("stream_drained", 64'(o_data_valid), 64'd0);

        // Backpressure
        i_data_ready = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            beat(DW'(i), 1'b0, w);
            chk("bp_accept", 64'(w), 64'd0);
        end
        chk_word("bp_held", 32'h04030201, 4'b1111, 1'b0);
        i_data       = 8'h08;
        i_data_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_stall_ready", 64'(o_data_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        chk("bp_still_held", 64'(o_data), 64'h04030201);
        i_data_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 64'(o_data_ready), 64'd1);
        @(posedge clk);
        #1;
        i_data_valid = 1'b0;
        chk_word("bp_w1", 32'h08070605, 4'b1111, 1'b0);
        @(posedge clk);
        #1;

        // Partial flush then lane-0 restart
        beat(8'hAA, 1'b0, w);
        beat(8'hBB, 1'b1, w);
        chk_word("flush2", 32'h0000BBAA, 4'b0011, 1'b1);
        beat(8'hCC, 1'b1, w);
        chk_word("flush_restart", 32'h000000CC, 4'b0001, 1'b1);
        beat(8'h5A, 1'b1, w);
        chk_word("last_first", 32'h0000005A, 4'b0001, 1'b1);
        beat(8'hA1, 1'b0, w);
        beat(8'hB2, 1'b0, w);
        beat(8'hC3, 1'b0, w);
        beat(8'hD4, 1'b1, w);
        chk_word("last_full", 32'hD4C3B2A1, 4'b1111, 1'b1);
        @(posedge clk);
        #1;

        // Reset mid-fill with a pending output word
        i_data_ready = 1'b0;
        for (int i = 1; i <= 4; i++) beat(DW'(i), 1'b0, w);
        beat(8'h11, 1'b0, w);
        beat(8'h22, 1'b0, w);
        rst_n = 1'b0;
        #2;
        chk_cleared("midreset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        i_data_ready = 1'b1;
        @(posedge clk);
        #1;
        beat(8'h33, 1'b0, w);
        beat(8'h44, 1'b0, w);
        beat(8'h55, 1'b0, w);
        beat(8'h66, 1'b0, w);
        chk_word("post_reset", 32'h66554433, 4'b1111, 1'b0);
        @(posedge clk);
        #1;

        // Random valid bubbles and downstream readiness
        rand_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            beat(DW'($urandom_range(0, 255)), 1'($urandom_range(0, 7) == 0), w);
        end
        rand_en      = 1'b0;
        i_data_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sbq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
